csp1_sequencer: RTL

- Stage scheduler for the CSP1_N bottleneck.
- Drives one shared CBS engine (conv + BN + SiLU, plus ADD and CONCAT ops) through the fixed CSP1_N stage list, one stage at a time, over a start/done handshake.
- For each stage it issues the op code, buffer selects, kernel/padding configuration and filter-bank index.
- Signals completion on a valid/ready result handshake.
- Sits between the network-level layer controller and the CBS engine / feature-map buffer bank.

---
 rtl/csp1_sequencer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/csp1_sequencer.sv
// csp1_sequencer: stage scheduler for the CSP1_N bottleneck.
// Walks the fixed CSP1_N stage list (CBS1, N x {RES1, RES2, ADD}, CBS2, CAT,
// CBSO) and drives one shared CBS engine one stage at a time over a
// start/done handshake, then offers the result on a valid/ready handshake.
//
// Optional feature: define CSP_TIMEOUT_EN to add a per-stage WAIT watchdog
// (eng_abort pulse, sticky err, ERROR state). Without it err/eng_abort are 0.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   start                 request a pass (sampled in IDLE, and ERROR)
//   busy                  high in every state except IDLE
//   eng_start             one-cycle pulse: engine begins the current stage
//   eng_op/k/pad          op (0 CONV, 1 ADD, 2 CONCAT), kernel, padding
//   eng_src_a/b, eng_dst  feature-map buffer selects
//   eng_bank              filter-bank index
//   eng_done              engine stage complete (honoured only in WAIT)
//   eng_abort             one-cycle pulse on watchdog expiry
//   stage_idx             current stage number
//   done_valid/ready      result handshake, result lives in buffer 6
//   err                   watchdog fired; sticky until the next start
module csp1_sequencer #(
  parameter int unsigned RES_N   = 1,
  parameter int unsigned BANK_W  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              eng_start,
  output logic [1:0]        eng_op,
  output logic [1:0]        eng_k,
  output logic              eng_pad,
  output logic [2:0]        eng_src_a,
  output logic [2:0]        eng_src_b,
  output logic [2:0]        eng_dst,
  output logic [BANK_W-1:0] eng_bank,
  input  logic              eng_done,
  output logic              eng_abort,
  output logic [3:0]        stage_idx,
  output logic              done_valid,
  input  logic              done_ready,
  output logic              err
);

  localparam int unsigned S     = 4 + 3 * RES_N;
  // Internal counter is one bit wider than stage_idx so RES_N up to 7 works.
  localparam int unsigned SW    = 5;
  localparam int unsigned CFG_W = 14 + BANK_W;
  localparam logic [1:0]  OP_CONV = 2'd0;
  localparam logic [1:0]  OP_ADD  = 2'd1;
  localparam logic [1:0]  OP_CAT  = 2'd2;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, NEXT, RESULT, ERROR
  } state_t;

  state_t            state;
  logic [SW-1:0]     stage_q, n_stage;
  logic [2:0]        r_q, n_r;      // residual unit counter
  logic [1:0]        ph_q, n_ph;    // position inside a residual unit
  logic [1:0]        c_op, c_k;
  logic              c_pad;
  logic [2:0]        c_a, c_b, c_dst;
  logic [BANK_W-1:0] c_bank;
  logic [CFG_W-1:0]  cfg_c;
  logic              last_c;

  assign stage_idx = stage_q[3:0];
  assign last_c    = (stage_q == SW'(S - 1));
  assign cfg_c     = {c_op, c_k, c_pad, c_a, c_b, c_dst, c_bank};

  // Position of the stage to be issued next and its engine configuration.
  always_comb begin
    n_stage = stage_q + SW'(1);
    n_r     = r_q;
    n_ph    = ph_q;
    if (stage_q != '0 && stage_q <= SW'(3 * RES_N)) begin
      if (ph_q == 2'd2) begin
        n_ph = 2'd0;
        n_r  = r_q + 3'd1;
      end else begin
        n_ph = ph_q + 2'd1;
      end
    end
    if (state == IDLE || state == ERROR) begin
      n_stage = '0;
      n_r     = '0;
      n_ph    = '0;
    end

    c_op   = OP_CONV;
    c_k    = 2'd0;
    c_pad  = 1'b0;
    c_a    = 3'd0;
    c_b    = 3'd0;
    c_dst  = 3'd0;
    c_bank = '0;
    if (n_stage == '0) begin
      c_k   = 2'd3;
      c_dst = 3'd1;
    end else if (n_stage <= SW'(3 * RES_N)) begin
      case (n_ph)
        2'd0: begin
          c_k    = 2'd1;
          c_a    = 3'd1;
          c_dst  = 3'd2;
          c_bank = BANK_W'(2 * int'(n_r) + 1);
        end
        2'd1: begin
          c_k    = 2'd3;
          c_pad  = 1'b1;
          c_a    = 3'd2;
          c_dst  = 3'd3;
          c_bank = BANK_W'(2 * int'(n_r) + 2);
        end
        default: begin
          c_op  = OP_ADD;
          c_a   = 3'd1;
          c_b   = 3'd3;
          c_dst = 3'd1;
        end
      endcase
    end else if (n_stage == SW'(3 * RES_N + 1)) begin
      c_k    = 2'd3;
      c_dst  = 3'd4;
      c_bank = BANK_W'(2 * RES_N + 1);
    end else if (n_stage == SW'(3 * RES_N + 2)) begin
      c_op  = OP_CAT;
      c_a   = 3'd1;
      c_b   = 3'd4;
      c_dst = 3'd5;
    end else begin
      c_k    = 2'd1;
      c_a    = 3'd5;
      c_dst  = 3'd6;
      c_bank = BANK_W'(2 * RES_N + 2);
    end
  end

`ifdef CSP_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wcnt;
`else
  assign err       = 1'b0;
  assign eng_abort = 1'b0;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      stage_q    <= '0;
      r_q        <= '0;
      ph_q       <= '0;
      busy       <= 1'b0;
      eng_start  <= 1'b0;
      done_valid <= 1'b0;
      {eng_op, eng_k, eng_pad, eng_src_a, eng_src_b, eng_dst, eng_bank} <= '0;
`ifdef CSP_TIMEOUT_EN
      wcnt       <= '0;
      err        <= 1'b0;
      eng_abort  <= 1'b0;
`endif
    end else begin
      eng_start <= 1'b0;
`ifdef CSP_TIMEOUT_EN
      eng_abort <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            eng_start <= 1'b1;
            stage_q   <= n_stage;
            r_q       <= n_r;
            ph_q      <= n_ph;
            {eng_op, eng_k, eng_pad, eng_src_a, eng_src_b, eng_dst, eng_bank} <= cfg_c;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef CSP_TIMEOUT_EN
          wcnt  <= '0;
`endif
        end
        WAIT: begin
          if (eng_done) begin
            if (last_c) begin
              state      <= RESULT;
              done_valid <= 1'b1;
              {eng_op, eng_k, eng_pad, eng_src_a, eng_src_b, eng_dst, eng_bank} <= '0;
            end else begin
              state <= NEXT;
            end
          end
`ifdef CSP_TIMEOUT_EN
          // A done in the expiry cycle is handled above and wins.
          else if (wcnt == CW'(TIMEOUT - 1)) begin
            state     <= ERROR;
            eng_abort <= 1'b1;
            err       <= 1'b1;
            {eng_op, eng_k, eng_pad, eng_src_a, eng_src_b, eng_dst, eng_bank} <= '0;
          end else begin
            wcnt <= wcnt + CW'(1);
          end
`endif
        end
        NEXT: begin
          state     <= ISSUE;
          eng_start <= 1'b1;
          stage_q   <= n_stage;
          r_q       <= n_r;
          ph_q      <= n_ph;
          {eng_op, eng_k, eng_pad, eng_src_a, eng_src_b, eng_dst, eng_bank} <= cfg_c;
        end
        RESULT: begin
          if (done_ready) begin
            state      <= IDLE;
            done_valid <= 1'b0;
            busy       <= 1'b0;
            stage_q    <= '0;
          end
        end
`ifdef CSP_TIMEOUT_EN
        ERROR: begin
          if (start) begin
            state     <= ISSUE;
            err       <= 1'b0;
            eng_start <= 1'b1;
            stage_q   <= n_stage;
            r_q       <= n_r;
            ph_q      <= n_ph;
            {eng_op, eng_k, eng_pad, eng_src_a, eng_src_b, eng_dst, eng_bank} <= cfg_c;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
